// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for pipeline stage boundaries. The main entry drives the
// outputs directly, and in_ready is a flop, so out_ready has no combinational path to it.
module pipe_skid_reg #(
    parameter int unsigned DATA_W       = 32,
    parameter bit          ZERO_INVALID = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    logic              mv_q, mv_d;
    logic              sv_q, sv_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              accept, drain;

    assign accept = in_valid & rdy_q;
    assign drain  = mv_q & out_ready;

    always_comb begin
        mv_d = mv_q;
        sv_d = sv_q;
        m_d  = m_q;
        s_d  = s_q;
        if (flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
            if (ZERO_INVALID) begin
                m_d = '0;
                s_d = '0;
            end
        end else if (sv_q) begin
            // in_ready is low while the skid entry is full, so only a drain can happen here
            if (drain) begin
                m_d  = s_q;
                sv_d = 1'b0;
                if (ZERO_INVALID) s_d = '0;
            end
        end else if (!mv_q) begin
            if (accept) begin
                m_d  = in_data;
                mv_d = 1'b1;
            end
        end else begin
            if (accept && drain) begin
                m_d = in_data;
            end else if (accept) begin
                s_d  = in_data;
                sv_d = 1'b1;
            end else if (drain) begin
                mv_d = 1'b0;
                if (ZERO_INVALID) m_d = '0;
            end
        end
        rdy_d = ~sv_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mv_q  <= 1'b0;
            sv_q  <= 1'b0;
            rdy_q <= 1'b1;
            m_q   <= '0;
            s_q   <= '0;
        end else begin
            mv_q  <= mv_d;
            sv_q  <= sv_d;
            rdy_q <= rdy_d;
            m_q   <= m_d;
            s_q   <= s_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = mv_q;
    assign out_data  = m_q;
    assign occupancy = {mv_q & sv_q, mv_q ^ sv_q};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three instances (71-bit, 8-bit, 8-bit hold-data) share one
// stimulus stream and are compared every cycle against a queue-based reference.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [70:0] in_data;

    logic        rdy71, v71, rdy8, v8, rdyz, vz;
    logic [70:0] d71;
    logic [7:0]  d8, dz;
    logic [1:0]  occ71, occ8, occz;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(71)) u71 (
        .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy71), .out_valid(v71), .out_data(d71), .out_ready(out_ready), .occupancy(occ71)
    );

    pipe_skid_reg #(.DATA_W(8)) u8 (
        .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(rdy8), .out_valid(v8), .out_data(d8), .out_ready(out_ready), .occupancy(occ8)
    );

    pipe_skid_reg #(.DATA_W(8), .ZERO_INVALID(1'b0)) uz (
        .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(rdyz), .out_valid(vz), .out_data(dz), .out_ready(out_ready), .occupancy(occz)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference: the stage is a FIFO of at most two beats; ready means "fewer than two held".
    logic [70:0] mq[$];
    logic [70:0] last_front;

    always @(posedge clk or negedge rst_n) begin
        bit acc, drn;
        if (!rst_n) begin
            mq.delete();
            last_front = '0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
            if (mq.size() > 0) last_front = mq[0];
        end
    end

    always @(negedge clk) begin
        int          sz;
        logic [70:0] f;
        if (chk_en) begin
            sz = mq.size();
            f  = (sz > 0) ? mq[0] : '0;
            check("u71.out_valid", 128'(v71), 128'(sz > 0));
            check("u71.in_ready",  128'(rdy71), 128'(sz < 2));
            check("u71.occupancy", 128'(occ71), 128'(sz));
            check("u71.out_data",  128'(d71), 128'(f));
            check("u8.out_valid",  128'(v8), 128'(sz > 0));
            check("u8.in_ready",   128'(rdy8), 128'(sz < 2));
            check("u8.occupancy",  128'(occ8), 128'(sz));
            check("u8.out_data",   128'(d8), 128'(f[7:0]));
            check("uz.out_valid",  128'(vz), 128'(sz > 0));
            check("uz.in_ready",   128'(rdyz), 128'(sz < 2));
            check("uz.occupancy",  128'(occz), 128'(sz));
            check("uz.out_data",   128'(dz), 128'((sz > 0) ? f[7:0] : last_front[7:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [70:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic lit(input string nm, input bit v, input logic [70:0] d, input logic [1:0] occ,
                       input bit rdy);
        check({nm, ".out_valid"}, 128'(v71), 128'(v));
        check({nm, ".out_data"},  128'(d71), 128'(d));
        check({nm, ".occupancy"}, 128'(occ71), 128'(occ));
        check({nm, ".in_ready"},  128'(rdy71), 128'(rdy));
    endtask

    initial begin
        logic [95:0] r;
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 0, '0, 2'd0, 1);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // back-to-back stream at full throughput
        drive(1, 71'h11, 1, 0); tick(); lit("stream1", 1, 71'h11, 2'd1, 1);
        drive(1, 71'h22, 1, 0); tick(); lit("stream2", 1, 71'h22, 2'd1, 1);
        drive(1, 71'h33, 1, 0); tick(); lit("stream3", 1, 71'h33, 2'd1, 1);
        drive(0, '0, 1, 0);     tick(); lit("stream4", 0, '0, 2'd0, 1);

        // stall: second beat lands in the skid entry, third waits upstream
        drive(1, 71'hA1, 0, 0); tick(); lit("stall1", 1, 71'hA1, 2'd1, 1);
        drive(1, 71'hA2, 0, 0); tick(); lit("stall2", 1, 71'hA1, 2'd2, 0);
        drive(1, 71'hA3, 0, 0); tick(); lit("stall3", 1, 71'hA1, 2'd2, 0);
        repeat (3) tick();               lit("stall_hold", 1, 71'hA1, 2'd2, 0);
        drive(1, 71'hA3, 1, 0); tick(); lit("stall4", 1, 71'hA2, 2'd1, 1);
        tick();                          lit("stall5", 1, 71'hA3, 2'd1, 1);
        drive(0, '0, 1, 0);     tick(); lit("stall6", 0, '0, 2'd0, 1);

        // flush beats a simultaneous accept
        drive(1, 71'h01, 0, 0); tick();
        drive(1, 71'h02, 0, 0); tick(); lit("flush0", 1, 71'h01, 2'd2, 0);
        drive(1, 71'h55, 0, 1); tick(); lit("flush1", 0, '0, 2'd0, 1);
        check("flush.uz_hold", 128'(dz), 128'(8'h01));
        drive(0, '0, 1, 0);
        repeat (3) tick();               lit("flush2", 0, '0, 2'd0, 1);

        // hold-data variant keeps the last payload after draining
        drive(1, 71'h7E, 1, 0); tick();
        check("zhold.v1", 128'(vz), 128'(1'b1));
        drive(0, '0, 1, 0);     tick();
        check("zhold.v0", 128'(vz), 128'(1'b0));
        check("zhold.d",  128'(dz), 128'(8'h7E));
        check("zero.d",   128'(d8), 128'(8'h00));

        // asynchronous reset between clock edges with the stage full
        drive(1, 71'hB1, 0, 0); tick();
        drive(1, 71'hB2, 0, 0); tick(); lit("areset0", 1, 71'hB1, 2'd2, 0);
        drive(0, '0, 0, 0);
        #2 rst_n = 1'b0;
        #1 lit("areset1", 0, '0, 2'd0, 1);
        check("areset1.uz_d",   128'(dz), 128'(8'h00));
        check("areset1.uz_rdy", 128'(rdyz), 128'(1'b1));
        tick();                          lit("areset2", 0, '0, 2'd0, 1);
        rst_n = 1'b1;
        drive(1, 71'h99, 1, 0); tick(); lit("areset3", 1, 71'h99, 2'd1, 1);
        drive(0, '0, 1, 0);     tick(); lit("areset4", 0, '0, 2'd0, 1);

        // randomized traffic with drifting downstream back-pressure and rare flushes
        for (int i = 0; i < 10000; i++) begin
            int unsigned rb;
            rb        = (i / 1000) % 4;
            r         = {$urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) <= rb);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = r[70:0];
            tick();
        end
        drive(0, '0, 1, 0);
        repeat (4) tick();
        lit("final", 0, '0, 2'd0, 1);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
